// File: rtl/and_reduce_seq.sv
// Sequential AND reduction: N operand words are folded into one WIDTH-bit result
// through a single shared 2-input AND, one word per clock, with valid/ready on both sides.
module and_reduce_seq #(
    parameter int N          = 2,
    parameter int WIDTH      = 1,
    parameter int EARLY_EXIT = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N*WIDTH-1:0]         in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(N+1)-1:0]     out_count,
    output logic                       busy
);

    localparam int CNT_W = $clog2(N + 1);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [N*WIDTH-1:0]   data_q;
    logic [WIDTH-1:0]     acc;
    logic [IDX_W-1:0]     idx;

    logic [WIDTH-1:0]     word_cur;
    logic [WIDTH-1:0]     acc_next;
    logic                 last_word;
    logic                 finish;

    // Word select is a compare-per-word mux so an idx value past N-1 can never
    // address outside the captured vector.
    always_comb begin
        word_cur = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == IDX_W'(i)) begin
                word_cur = data_q[i*WIDTH +: WIDTH];
            end
        end
    end

    assign acc_next  = acc & word_cur;
    assign last_word = (idx == IDX_W'(N - 1));
    assign finish    = last_word || ((EARLY_EXIT != 0) && (acc_next == '0));

    // The operand copy is pure data: it is only meaningful after a capture in IDLE.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            data_q <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            idx       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc      <= '1;
                        idx      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    idx <= idx + IDX_W'(1);
                    if (finish) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_data  <= acc_next;
                        out_count <= CNT_W'(idx) + CNT_W'(1);
                    end
                end
                DONE: begin
                    // Result registers are left untouched so they hold after the transfer.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_and_reduce_seq.sv
// Bench for and_reduce_seq: directed scenarios on three configurations plus
// randomized traffic scored against a word-by-word AND reference.
module tb_and_reduce_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    // index 0: N=4 WIDTH=8 EARLY_EXIT=0, index 1: N=4 WIDTH=8 EARLY_EXIT=1
    logic        vin  [2];
    logic        rdy  [2];
    logic        vout [2];
    logic        ordy [2];
    logic        bsy  [2];
    logic [31:0] din  [2];
    logic [7:0]  dout [2];
    logic [2:0]  cnt  [2];

    logic        c_vin, c_rdy, c_vout, c_ordy, c_bsy;
    logic [3:0]  c_din, c_dout;
    logic [0:0]  c_cnt;

    int total = 0;
    int bad   = 0;

    and_reduce_seq #(.N(4), .WIDTH(8), .EARLY_EXIT(0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(vin[0]), .in_ready(rdy[0]), .in_data(din[0]),
        .out_valid(vout[0]), .out_ready(ordy[0]), .out_data(dout[0]), .out_count(cnt[0]),
        .busy(bsy[0])
    );

    and_reduce_seq #(.N(4), .WIDTH(8), .EARLY_EXIT(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(vin[1]), .in_ready(rdy[1]), .in_data(din[1]),
        .out_valid(vout[1]), .out_ready(ordy[1]), .out_data(dout[1]), .out_count(cnt[1]),
        .busy(bsy[1])
    );

    and_reduce_seq #(.N(1), .WIDTH(4), .EARLY_EXIT(0)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_vin), .in_ready(c_rdy), .in_data(c_din),
        .out_valid(c_vout), .out_ready(c_ordy), .out_data(c_dout), .out_count(c_cnt),
        .busy(c_bsy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: AND the words in order, stopping at an all-zero partial result when early exit is on.
    function automatic void ref_and(input logic [31:0] v, input bit ee,
                                    output logic [7:0] d, output logic [2:0] c);
        d = 8'hFF;
        c = 3'd0;
        for (int i = 0; i < 4; i++) begin
            d = d & v[i*8 +: 8];
            c = c + 3'd1;
            if (ee && d == 8'h00) break;
        end
    endfunction

    // Offers one vector to DUT k and returns cycles from the handshake cycle to out_valid.
    task automatic run_one(input int k, input logic [31:0] vec, output int lat);
        chk("accept_ready", {31'd0, rdy[k]}, 32'd1);
        vin[k] = 1'b1;
        din[k] = vec;
        tick;
        vin[k] = 1'b0;
        din[k] = $urandom;
        lat = 1;
        while (!vout[k] && lat < 64) begin
            tick;
            lat++;
        end
    endtask

    initial begin
        int          lat;
        int          sent, got, cyc;
        logic [31:0] v;
        logic [7:0]  ed;
        logic [2:0]  ec;
        logic        hold;
        logic [11:0] held;
        logic [31:0] q [$];

        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            vin[k] = 1'b0; din[k] = '0; ordy[k] = 1'b1;
        end
        c_vin = 1'b0; c_din = '0; c_ordy = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("rst_in_ready",  {31'd0, rdy[k]},  32'd1);
            chk("rst_out_valid", {31'd0, vout[k]}, 32'd0);
            chk("rst_busy",      {31'd0, bsy[k]},  32'd0);
            chk("rst_out_data",  {24'd0, dout[k]}, 32'd0);
            chk("rst_out_count", {29'd0, cnt[k]},  32'd0);
        end
        chk("rst_c_in_ready", {31'd0, c_rdy}, 32'd1);
        chk("rst_c_out_data", {28'd0, c_dout}, 32'd0);

        // basic reduction FF,F0,3C,FE with the consumer always ready
        run_one(0, 32'hFE3CF0FF, lat);
        chk("basic_latency", lat, 32'd5);
        chk("basic_data",    {24'd0, dout[0]}, 32'h30);
        chk("basic_count",   {29'd0, cnt[0]},  32'd4);
        chk("basic_busy",    {31'd0, bsy[0]},  32'd1);
        chk("basic_no_rdy",  {31'd0, rdy[0]},  32'd0);
        tick;
        chk("basic_one_cycle", {31'd0, vout[0]}, 32'd0);
        chk("basic_idle_rdy",  {31'd0, rdy[0]},  32'd1);
        chk("basic_idle_busy", {31'd0, bsy[0]},  32'd0);
        chk("basic_hold_data", {24'd0, dout[0]}, 32'h30);

        // backpressure for 10 cycles
        ordy[0] = 1'b0;
        run_one(0, 32'hFE3CF0FF, lat);
        chk("bp_latency", lat, 32'd5);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", {31'd0, vout[0]}, 32'd1);
            chk("bp_data",  {24'd0, dout[0]}, 32'h30);
            chk("bp_count", {29'd0, cnt[0]},  32'd4);
            chk("bp_ready", {31'd0, rdy[0]},  32'd0);
            tick;
        end
        chk("bp_still_valid", {31'd0, vout[0]}, 32'd1);
        ordy[0] = 1'b1;
        tick;
        chk("bp_release_valid", {31'd0, vout[0]}, 32'd0);
        chk("bp_release_ready", {31'd0, rdy[0]},  32'd1);

        // early exit: 0F,F0 gives zero after two words
        run_one(1, 32'hFFFFF00F, lat);
        chk("ee_latency", lat, 32'd3);
        chk("ee_data",    {24'd0, dout[1]}, 32'h00);
        chk("ee_count",   {29'd0, cnt[1]},  32'd2);
        tick;
        chk("ee_idle_rdy", {31'd0, rdy[1]}, 32'd1);

        // early exit dut with no zero: full length
        run_one(1, 32'hF1F3F7FF, lat);
        chk("ee_full_latency", lat, 32'd5);
        chk("ee_full_data",    {24'd0, dout[1]}, 32'hF1);
        chk("ee_full_count",   {29'd0, cnt[1]},  32'd4);
        tick;

        // N=1 configuration
        c_vin = 1'b1;
        c_din = 4'hA;
        tick;
        c_vin = 1'b0;
        c_din = 4'h0;
        lat = 1;
        while (!c_vout && lat < 64) begin
            tick;
            lat++;
        end
        chk("n1_latency", lat, 32'd2);
        chk("n1_data",    {28'd0, c_dout}, 32'hA);
        chk("n1_count",   {31'd0, c_cnt},  32'd1);
        tick;
        chk("n1_idle_rdy", {31'd0, c_rdy}, 32'd1);

        // reset during the second RUN cycle
        vin[0] = 1'b1;
        din[0] = 32'hFFFFFFFF;
        tick;
        vin[0] = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("mid_rst_ready", {31'd0, rdy[0]},  32'd1);
        chk("mid_rst_busy",  {31'd0, bsy[0]},  32'd0);
        chk("mid_rst_data",  {24'd0, dout[0]}, 32'd0);
        chk("mid_rst_count", {29'd0, cnt[0]},  32'd0);
        for (int i = 0; i < 6; i++) begin
            chk("mid_rst_no_valid", {31'd0, vout[0]}, 32'd0);
            tick;
        end
        run_one(0, 32'h7F3F1FFF, lat);
        chk("post_rst_latency", lat, 32'd5);
        chk("post_rst_data",    {24'd0, dout[0]}, 32'h1F);
        chk("post_rst_count",   {29'd0, cnt[0]},  32'd4);
        tick;

        // randomized traffic on both 4-word configurations
        for (int k = 0; k < 2; k++) begin
            q.delete();
            sent = 0; got = 0; cyc = 0; hold = 1'b0; held = '0;
            while ((sent < 1000 || got < sent) && cyc < 40000) begin
                if (hold) chk("rnd_hold", {19'd0, vout[k], dout[k], cnt[k]}, {20'd0, held});
                vin[k]  = (sent < 1000) && ($urandom_range(0, 3) != 0);
                din[k]  = (($urandom_range(0, 1) == 0) ? 32'hFFFFFFFF : 32'h0) | $urandom;
                ordy[k] = ($urandom_range(0, 2) != 0);
                if (vin[k] && rdy[k]) begin
                    q.push_back(din[k]);
                    sent++;
                end
                if (vout[k] && ordy[k]) begin
                    if (q.size() == 0) begin
                        chk("rnd_duplicate", 32'd1, 32'd0);
                    end else begin
                        v = q.pop_front();
                        ref_and(v, k == 1, ed, ec);
                        chk("rnd_data",  {24'd0, dout[k]}, {24'd0, ed});
                        chk("rnd_count", {29'd0, cnt[k]},  {29'd0, ec});
                        got++;
                    end
                end
                hold = vout[k] && !ordy[k];
                held = {vout[k], dout[k], cnt[k]};
                tick;
                cyc++;
            end
            vin[k]  = 1'b0;
            ordy[k] = 1'b1;
            chk("rnd_received", got, 32'd1000);
            chk("rnd_pending",  q.size(), 32'd0);
            tick;
            tick;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
